// File: rtl/mux4_reg_pkg.sv
// Shared definitions for the registered 4:1 word multiplexer.
// - DATA_W : default datapath width used by the pipeline steering elements
// - SEL_W  : select width; four inputs means two select bits
// - SEL_*  : select codes naming which input word is steered to the output
package mux4_reg_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 2;

  localparam logic [SEL_W-1:0] SEL_A = 2'd0;
  localparam logic [SEL_W-1:0] SEL_B = 2'd1;
  localparam logic [SEL_W-1:0] SEL_C = 2'd2;
  localparam logic [SEL_W-1:0] SEL_D = 2'd3;

endpackage

// File: rtl/mux4_comb.sv
// Combinational 4:1 word select with no state.
// Ports:
// - select : SEL_W-bit code, SEL_A..SEL_D choose a..d
// - a..d   : NB-bit candidate words
// - data   : NB-bit selected word, a pure pass-through of the chosen input
module mux4_comb
  import mux4_reg_pkg::*;
#(
  parameter int NB = DATA_W
) (
  input  logic [SEL_W-1:0] select,
  input  logic [NB-1:0]    a,
  input  logic [NB-1:0]    b,
  input  logic [NB-1:0]    c,
  input  logic [NB-1:0]    d,
  output logic [NB-1:0]    data
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives data and
    // no latch can be inferred, even though all four codes are listed.
    data = a;
    case (select)
      SEL_A: data = a;
      SEL_B: data = b;
      SEL_C: data = c;
      SEL_D: data = d;
      default: data = a;
    endcase
  end

endmodule

// File: rtl/mux4_reg.sv
// Registered 4:1 word multiplexer for pipeline steering (PC source, ALU
// operand, write-back). The selected word appears on o_data one cycle after
// i_select and the inputs are sampled; there is no enable and no hold.
// Ports:
// - i_clock   : single clock, all state on the rising edge
// - i_reset_n : asynchronous active-low reset, clears o_data immediately
// - i_select  : 0->i_a, 1->i_b, 2->i_c, 3->i_d
// - i_a..i_d  : NB-bit input words
// - o_data    : registered selected word (no combinational path from inputs)
module mux4_reg
  import mux4_reg_pkg::*;
#(
  parameter int NB        = DATA_W,
  parameter int NB_SELECT = SEL_W   // only 2 is supported
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic [NB_SELECT-1:0] i_select,
  input  logic [NB-1:0]        i_a,
  input  logic [NB-1:0]        i_b,
  input  logic [NB-1:0]        i_c,
  input  logic [NB-1:0]        i_d,
  output logic [NB-1:0]        o_data
);

  logic [NB-1:0] picked;

  mux4_comb #(
    .NB (NB)
  ) u_mux4_comb (
    .select (i_select),
    .a      (i_a),
    .b      (i_b),
    .c      (i_c),
    .d      (i_d),
    .data   (picked)
  );

  // The asynchronous clear wins over any edge, so a selection pending at the
  // moment reset asserts is discarded.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the edge.
    if (!i_reset_n) begin
      o_data <= '0;
    end else begin
      o_data <= picked;
    end
  end

endmodule

// File: tb/tb_mux4_reg.sv
// Self-checking bench for mux4_reg: directed reset/sweep/back-to-back/input
// change/mid-run reset sequences plus randomized traffic compared against a
// word-array reference model.
module tb_mux4_reg;

  logic        clock;
  logic        reset_n;
  logic [1:0]  select;
  logic [31:0] a, b, c, d;
  logic [31:0] data;

  int checks;
  int errors;

  mux4_reg #(
    .NB        (32),
    .NB_SELECT (2)
  ) dut (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_select  (select),
    .i_a       (a),
    .i_b       (b),
    .i_c       (c),
    .i_d       (d),
    .o_data    (data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic edge_then_sample();
    @(posedge clock);
    @(negedge clock);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [31:0] c_val;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sweep_exp[4];
  logic [31:0] words[4];
  logic [31:0] model_exp;

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b1;
    select  = 2'd0;
    a = 32'd1;
    b = 32'd80;
    c = 32'd250;
    d = 32'd999;

    sweep_exp[0] = 32'd1;
    sweep_exp[1] = 32'd80;
    sweep_exp[2] = 32'd250;
    sweep_exp[3] = 32'd999;

    // Back-to-back select changes, then a data change on a held select.
    vecs.push_back('{"b2b_sel3",   2'd3, 32'd250,      32'd999});
    vecs.push_back('{"b2b_sel0",   2'd0, 32'd250,      32'd1});
    vecs.push_back('{"b2b_sel2",   2'd2, 32'd250,      32'd250});
    vecs.push_back('{"b2b_sel1",   2'd1, 32'd250,      32'd80});
    vecs.push_back('{"hold_sel2",  2'd2, 32'd250,      32'd250});
    vecs.push_back('{"c_all_ones", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{"c_back",     2'd2, 32'd250,      32'd250});

    // Reset asserted before any clock edge must clear the output at once.
    #1 reset_n = 1'b0;
    #1 check("reset_async", data, 32'd0);
    repeat (2) begin
      @(negedge clock);
      check("reset_hold", data, 32'd0);
    end

    // Release on a falling edge; the next rising edge loads input a.
    reset_n = 1'b1;

    // Sweep each select for 100 ns (ten cycles).
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      repeat (10) begin
        edge_then_sample();
        check($sformatf("sweep_sel%0d", s), data, sweep_exp[s]);
      end
    end

    // Table-driven vectors, one edge each.
    for (int i = 0; i < vecs.size(); i++) begin
      select = vecs[i].sel;
      c      = vecs[i].c_val;
      edge_then_sample();
      check(vecs[i].name, data, vecs[i].exp);
    end

    // Mid-run reset pulse between edges.
    select = 2'd3;
    edge_then_sample();
    check("pre_reset_999", data, 32'd999);
    #1 reset_n = 1'b0;
    #1 check("midrun_reset_clear", data, 32'd0);
    #1 reset_n = 1'b1;
    edge_then_sample();
    check("post_reset_999", data, 32'd999);

    // Reset held across an edge discards the pending selection.
    select  = 2'd1;
    reset_n = 1'b0;
    edge_then_sample();
    check("reset_over_edge", data, 32'd0);
    reset_n = 1'b1;
    edge_then_sample();
    check("release_sel1", data, 32'd80);

    // Randomized traffic against the word-array model.
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 4; k++) words[k] = $urandom;
      select = 2'($urandom_range(0, 3));
      a = words[0];
      b = words[1];
      c = words[2];
      d = words[3];
      model_exp = words[select];
      if ($urandom_range(0, 15) == 0) begin
        #1 reset_n = 1'b0;
        #1 check("rand_async_reset", data, 32'd0);
        #1 reset_n = 1'b1;
      end
      edge_then_sample();
      check("rand_pick", data, model_exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a runaway run.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
